// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment scan controller:
//   - segment bit positions inside the 8-bit {dp,g,f,e,d,c,b,a} bus
//   - SEG_OFF: the all-segments-off pattern (active-high form)
//   - hex7(): nibble to active-high gfedcba decode
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Active-high gfedcba pattern for one hex nibble (lower-case b and d).
    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
// Free-running digit-slot prescaler. cnt counts 0..DIV-1 and wraps.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (cnt -> 0)
//   cnt        current position inside the digit slot
//   slot_tick  high in the last cycle of a slot (cnt == DIV-1)
// ---------------------------------------------------------------------------
module scan_prescaler #(
    parameter int DIV   = 10,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             slot_tick
);

    assign slot_tick = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (slot_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// N-digit multiplexed seven-segment scan controller with its own prescaler,
// frame-coherent input snapshot, per-digit enables, decimal points,
// leading-zero blanking and an all-off dead time at the start of each slot.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   value       hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp          decimal point per digit
//   digit_en    per-digit anode enable
//   blank_lz    leading-zero blanking enable
//   LEDSEL      one-hot anode select (inverted when ACTIVE_LOW)
//   LEDOUT      {dp,g,f,e,d,c,b,a} (inverted when ACTIVE_LOW)
//   frame_tick  one-cycle pulse after the snapshot is refreshed
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 100000000,
    parameter int SCAN_HZ      = 5000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   LEDSEL,
    output logic [7:0]              LEDOUT,
    output logic                    frame_tick
);
    import seg7_pkg::*;

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // XOR masks that turn the active-high internal view into pin polarity.
    localparam logic [NUM_DIGITS-1:0] SEL_POL = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]            SEG_POL = {8{ACTIVE_LOW}};

    if (DIV < 2) begin : g_div_check
        $error("seg7_scan_ctrl: CLK_HZ/SCAN_HZ must be at least 2");
    end
    if (BLANK_CYCLES >= DIV) begin : g_blank_check
        $error("seg7_scan_ctrl: BLANK_CYCLES must be smaller than CLK_HZ/SCAN_HZ");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_digits_check
        $error("seg7_scan_ctrl: NUM_DIGITS must be 1..8");
    end

    logic [CNT_W-1:0] cnt;
    logic             slot_tick;
    logic [IDX_W-1:0] idx;
    logic             frame_start;

    logic [4*NUM_DIGITS-1:0] value_snap;
    logic [NUM_DIGITS-1:0]   dp_snap;
    logic [NUM_DIGITS-1:0]   en_snap;
    logic                    blz_snap;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nibble;
    logic [NUM_DIGITS-1:0]   sel_n;
    logic [7:0]              seg_n;

    scan_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .slot_tick (slot_tick)
    );

    assign frame_start = (cnt == '0) && (idx == '0);

    // Walk from the most significant digit down; a digit is blanked while
    // every nibble above it (and itself) is zero. Digit 0 always shows.
    always_comb begin : lz_mask
        logic seen_nz;
        lz_blank = '0;
        seen_nz  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (value_snap[4*i +: 4] != 4'h0) begin
                seen_nz = 1'b1;
            end
            lz_blank[i] = blz_snap & ~seen_nz;
        end
    end

    // Next output pattern in active-high form; dead time and disabled digits
    // give all anodes off and all segments off.
    always_comb begin
        cur_nibble = value_snap[4*int'(idx) +: 4];
        sel_n      = '0;
        seg_n      = SEG_OFF;
        if ((cnt >= CNT_W'(BLANK_CYCLES)) && en_snap[idx]) begin
            sel_n[idx]   = 1'b1;
            seg_n[6:0]   = lz_blank[idx] ? 7'h00 : hex7(cur_nibble);
            seg_n[SEG_DP] = dp_snap[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            value_snap <= '0;
            dp_snap    <= '0;
            en_snap    <= '0;
            blz_snap   <= 1'b0;
            frame_tick <= 1'b0;
            LEDSEL     <= SEL_POL;
            LEDOUT     <= SEG_OFF ^ SEG_POL;
        end else begin
            if (slot_tick) begin
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            if (frame_start) begin
                value_snap <= value;
                dp_snap    <= dp;
                en_snap    <= digit_en;
                blz_snap   <= blank_lz;
            end
            frame_tick <= frame_start;
            LEDSEL     <= sel_n ^ SEL_POL;
            LEDOUT     <= seg_n ^ SEG_POL;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised N-digit multiplexed seven-segment scan controller. It is the successor to the fixed 4-digit, externally clocked LED mux on the board top level. It contains its own scan prescaler, a frame-coherent input snapshot, per-digit enables, decimal points, leading-zero blanking and anti-ghosting dead time. It sits between the system's display data (for example gpo2) and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8)
- CLK_HZ, 100000000, input clock frequency
- SCAN_HZ, 5000, digit-advance rate; DIV = CLK_HZ/SCAN_HZ cycles per digit slot
- BLANK_CYCLES, 16, all-off dead time at the start of each digit slot
- ACTIVE_LOW, 1, 1 = LEDSEL and LEDOUT are driven active-low (board default)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost)
- dp  in  NUM_DIGITS  decimal point per digit
- digit_en  in  NUM_DIGITS  0 = anode for that digit is never asserted
- blank_lz  in  1  leading-zero blanking enable
- LEDSEL  out  NUM_DIGITS  one-hot anode select (polarity per ACTIVE_LOW)
- LEDOUT  out  8  {dp,g,f,e,d,c,b,a} segments (polarity per ACTIVE_LOW)
- frame_tick  out  1  one-cycle pulse: snapshot updated

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Elaboration checks: DIV>=2 and BLANK_CYCLES<DIV are required; any violation is an elaboration error. cnt width is $clog2(DIV).
- State:
  - prescaler cnt counts 0..DIV-1, then wraps.
  - digit index idx advances 0..NUM_DIGITS-1 when cnt==DIV-1, then wraps to 0.
- Frame start is the cycle with cnt==0 and idx==0.
  - At the end of that cycle, value, dp, digit_en and blank_lz are latched into the snapshot.
  - frame_tick is 1 in the following cycle only.
  - Input changes mid-frame never affect the current frame (no tearing).
- Outputs are registered. Outputs in cycle k are a function of state and snapshot in cycle k-1 (1-cycle latency).
- Anode drive:
  - Anode idx is asserted iff cnt>=BLANK_CYCLES and snapshot digit_en[idx]==1.
  - Otherwise all anodes are inactive and all segments are off.
- Segments: LEDOUT = {dp_snap[idx], hex7(nibble idx)}, or segments off (dp still honoured) when the digit is LZ-blanked.
- Leading-zero blanking: when blank_lz_snap==1, digits from NUM_DIGITS-1 downward whose nibble is 0 are blanked until the first nonzero nibble. Digit 0 is never blanked.
- Hex decode (active-high gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- ACTIVE_LOW=1 inverts both LEDSEL and all 8 LEDOUT bits.
- Reset:
  - cnt=0, idx=0, snapshot=0, frame_tick=0.
  - LEDSEL all inactive, LEDOUT all segments off (0xFF when active-low).
  - Reset asserted mid-frame takes effect on the next edge. The first frame start is the first cycle after rst deasserts.
- Boundary cases:
  - NUM_DIGITS=1: idx stays 0 and every slot is a frame start.
  - All digit_en=0: outputs stay all-off, frame_tick still pulses.

Decomposition:
- Package seg7_pkg:
  - HEX7 16-entry table or function
  - segment bit-position constants (SEG_A..SEG_G, SEG_DP)
  - SEG_OFF constant
- Sub-module scan_prescaler(DIV): owns cnt and emits slot_tick and cnt for the dead-time comparison.
- Snapshot, LZ-blank mask, idx and output registers stay in seg7_scan_ctrl.

Test Plan:
- Base configuration for all scenarios: CLK_HZ=1000, SCAN_HZ=100 (DIV=10), BLANK_CYCLES=2, NUM_DIGITS=4, ACTIVE_LOW=1.
- Reset and slot timing: release rst at cycle 0 with value=16'h1234, digit_en=4'hF, dp=0, blank_lz=0.
  - frame_tick=1 at cycle 1.
  - LEDSEL=4'b1110 and LEDOUT=8'h99 ("4") in cycles 3..10.
  - LEDSEL=4'b1111 in cycles 11..12.
  - LEDSEL=4'b1101 with LEDOUT=8'hB0 ("3") in cycles 13..20.
  - Frame period is 40 cycles.
- Hex and dp: value=16'h8F0A with dp=4'b0100.
  - digit0 LEDOUT=8'h88 ("A")
  - digit1 8'hC0 ("0")
  - digit2 8'h0E ("F" plus dp)
  - digit3 8'h80 ("8")
- Leading-zero blanking: value=16'h0005, blank_lz=1.
  - Digits 3..1 have anodes asserted with LEDOUT=8'hFF.
  - digit0 LEDOUT=8'h92 ("5").
  - value=16'h0000 shows "0" on digit0 only.
- Snapshot coherence: change value from 16'h1111 to 16'h2222 at cycle 15 (mid-frame).
  - All digits show "1" (8'hF9) until the next frame.
  - After frame_tick at cycle 41, all digits show "2" (8'hA4).
- digit_en and mid-frame reset: digit_en=4'b1010 → LEDSEL never equals 4'b1110 or 4'b1011.
  - Assert rst at cycle 25: at cycle 26 LEDSEL=4'b1111 and LEDOUT=8'hFF.
  - After release, timing restarts exactly as in the first scenario.
